// File: rtl/ahb_arb_pkg.sv
// Shared encodings and defaults for the AHB bus arbiter.
package ahb_arb_pkg;

   localparam int NUM_M_DEF     = 4;
   localparam int MAX_BEATS_DEF = 16;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      ST_DEFAULT = 2'b00,
      ST_OWNED   = 2'b01,
      ST_LOCKED  = 2'b10
   } arb_state_e;

   function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
      idx_to_onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin search: first requester starting at (last+1) mod 4.
module ahb_rr_picker (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] cand;

   // Walk from farthest to nearest so the nearest requester after 'last' wins.
   always_comb begin
      valid = 1'b0;
      idx   = 2'd0;
      cand  = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         cand = last + 2'(i);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter for masters sharing the AHB-to-APB bridge: round-robin with
// locked transfers, burst-length tenure limit and a default master.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_DEFAULT | nobody requested at the last arbitration; DEF_M granted
// ST_OWNED   | a requesting master holds the grant
// ST_LOCKED  | granted master holds hlock; tenure limit ignored
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_M     = NUM_M_DEF,
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int DEF_M     = 0
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic [NUM_M-1:0] hbusreq,
   input  logic [NUM_M-1:0] hlock,
   input  logic [1:0]       htrans,
   input  logic             hready,
   output logic [NUM_M-1:0] hgrant,
   output logic [1:0]       hmaster,
   output logic             hmastlock
);

   localparam logic [4:0] MAX_CNT  = 5'(MAX_BEATS);
   localparam logic [1:0] DEF_IDX  = 2'(DEF_M);
   localparam logic [1:0] LAST_RST = 2'd3;

   arb_state_e state, state_nxt;
   logic [1:0] grant_idx, grant_nxt;
   logic [1:0] last_owner, last_nxt;
   logic [4:0] tenure_cnt, tenure_nxt;
   logic       arb_pt;
   logic       beat;
   logic       in_burst;
   logic       pick_valid;
   logic [1:0] pick_idx;

   ahb_rr_picker u_picker (
      .req   (hbusreq),
      .last  (last_owner),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign in_burst = (htrans == HTRANS_SEQ);
   assign beat     = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

   // Arbitration decision, grant selection and tenure counting.
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant_idx;
      last_nxt   = last_owner;
      tenure_nxt = tenure_cnt;
      arb_pt     = 1'b0;
      if (hready) begin
         if (state == ST_LOCKED) begin
            arb_pt = !hlock[grant_idx] && !in_burst;
         end else begin
            arb_pt = !in_burst || (tenure_cnt == MAX_CNT);
         end

         if (beat && (tenure_cnt != MAX_CNT)) begin
            tenure_nxt = tenure_cnt + 5'd1;
         end

         if (arb_pt) begin
            if (pick_valid) begin
               grant_nxt = pick_idx;
               last_nxt  = pick_idx;
               state_nxt = hlock[pick_idx] ? ST_LOCKED : ST_OWNED;
            end else begin
               grant_nxt = DEF_IDX;
               state_nxt = ST_DEFAULT;
            end
            // A saturated owner that wins again still starts a fresh tenure.
            if ((grant_nxt != grant_idx) || (tenure_cnt == MAX_CNT)) begin
               tenure_nxt = 5'd0;
            end
         end
      end
   end

   // Arbiter state register; everything frozen while hready is low.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state      <= ST_DEFAULT;
         grant_idx  <= DEF_IDX;
         last_owner <= LAST_RST;
         tenure_cnt <= 5'd0;
         hgrant     <= idx_to_onehot(DEF_IDX);
      end else begin
         state      <= state_nxt;
         grant_idx  <= grant_nxt;
         last_owner <= last_nxt;
         tenure_cnt <= tenure_nxt;
         hgrant     <= idx_to_onehot(grant_nxt);
      end
   end

   // Address-phase owner follows the grant one hready-qualified cycle later.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         hmaster   <= 2'd0;
         hmastlock <= 1'b0;
      end else if (hready) begin
         hmaster   <= grant_idx;
         hmastlock <= hlock[grant_idx];
      end
   end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios plus random
// traffic, checked every cycle against a behavioural arbitration model.
module tb_ahb_bus_arbiter;

   localparam int MAXB = 16;
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

   logic       hclk = 1'b0;
   logic       hresetn = 1'b0;
   logic [3:0] hbusreq = 4'b0;
   logic [3:0] hlock = 4'b0;
   logic [1:0] htrans = 2'b0;
   logic       hready = 1'b1;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic       hmastlock;

   always #5 hclk = ~hclk;

   ahb_bus_arbiter dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .htrans    (htrans),
      .hready    (hready),
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .hmastlock (hmastlock)
   );

   typedef struct {
      logic [3:0] g;
      logic [1:0] m;
      logic       ml;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: who owns the grant, who owned it last, locked flag, beat count
   int m_owner = 0, m_last = 3, m_cnt = 0, m_hmaster = 0;
   bit m_locked = 1'b0, m_mlock = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_last = 3; m_cnt = 0; m_hmaster = 0;
      m_locked = 1'b0; m_mlock = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] req, input logic [3:0] lock,
                             input logic [1:0] trans, input logic rdy);
      int  win, nxt;
      bit  arb, active;
      if (!rdy) return;
      m_hmaster = m_owner;
      m_mlock   = lock[m_owner];
      active    = (trans == T_NONSEQ) || (trans == T_SEQ);
      if (m_locked) arb = !lock[m_owner] && (trans != T_SEQ);
      else          arb = (trans != T_SEQ) || (m_cnt == MAXB);
      if (!arb) begin
         if (active && m_cnt < MAXB) m_cnt++;
         return;
      end
      win = -1;
      for (int k = 1; k <= 4; k++)
         if (win < 0 && req[(m_last + k) % 4]) win = (m_last + k) % 4;
      if (win < 0) begin
         nxt = 0;
         m_locked = 1'b0;
      end else begin
         nxt = win;
         m_last = win;
         m_locked = lock[win];
      end
      if (nxt != m_owner || m_cnt == MAXB) m_cnt = 0;
      else if (active && m_cnt < MAXB) m_cnt++;
      m_owner = nxt;
   endtask

   task automatic push_exp();
      exp_t e;
      e.g  = 4'b0001 << m_owner;
      e.m  = 2'(m_hmaster);
      e.ml = m_mlock;
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic [3:0] req, input logic [3:0] lock,
                        input logic [1:0] trans, input logic rdy);
      @(negedge hclk);
      hresetn = 1'b1;
      hbusreq = req;
      hlock   = lock;
      htrans  = trans;
      hready  = rdy;
      model_step(req, lock, trans, rdy);
      push_exp();
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge hclk);
         #2;
         hresetn = 1'b0;
         model_reset();
         push_exp();
         if (k == 0) begin
            #1;
            check("async_rst_hgrant", hgrant, 4'b0001);
            check("async_rst_hmaster", hmaster, 2'd0);
            check("async_rst_hmastlock", hmastlock, 1'b0);
         end
      end
   endtask

   // Monitor: compare DUT outputs with the oldest expectation after each edge.
   initial begin
      forever begin
         @(posedge hclk);
         #1;
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_hgrant", hgrant, e.g);
            check("sb_hmaster", hmaster, e.m);
            check("sb_hmastlock", hmastlock, e.ml);
         end
      end
   end

   initial begin
      int order[5];
      int moved;
      logic [3:0] req;
      logic [1:0] tr;
      int r;
      order = '{0, 1, 2, 3, 0};

      do_reset(2);

      // idle after reset: default master stays granted
      for (int i = 0; i < 5; i++) begin
         cycle(4'b0000, 4'b0000, T_IDLE, 1'b1);
         @(posedge hclk); #2;
         check("idle_hgrant", hgrant, 4'b0001);
         check("idle_hmaster", hmaster, 2'd0);
         check("idle_hmastlock", hmastlock, 1'b0);
      end

      // all request, NONSEQ every cycle: one new master per cycle
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
         @(posedge hclk); #2;
         check("rr_hgrant", hgrant, 4'b0001 << order[i]);
      end

      // master 2 alone in a long burst, master 1 joins at beat 5; the
      // handover edge is the beat after the counter has saturated
      moved = -1;
      cycle(4'b0100, 4'b0000, T_NONSEQ, 1'b1);
      @(posedge hclk); #2;
      check("burst_start_hgrant", hgrant, 4'b0100);
      for (int b = 2; b <= 20; b++) begin
         req = (b >= 5) ? 4'b0110 : 4'b0100;
         cycle(req, 4'b0000, T_SEQ, 1'b1);
         @(posedge hclk); #2;
         if (moved < 0 && hgrant == 4'b0010) moved = b;
      end
      check("burst_handover_beat", moved, MAXB + 2);

      // master 3 locked through long SEQ traffic with everyone requesting
      cycle(4'b1000, 4'b1000, T_NONSEQ, 1'b1);
      @(posedge hclk); #2;
      check("lock_grant", hgrant, 4'b1000);
      for (int i = 0; i < 30; i++) begin
         cycle(4'b1111, 4'b1000, T_SEQ, 1'b1);
         @(posedge hclk); #2;
         check("lock_hold_hgrant", hgrant, 4'b1000);
         check("lock_hold_hmastlock", hmastlock, 1'b1);
      end
      cycle(4'b1111, 4'b0000, T_SEQ, 1'b1);
      @(posedge hclk); #2;
      check("lock_drop_in_burst", hgrant, 4'b1000);
      cycle(4'b1111, 4'b0000, T_IDLE, 1'b1);
      @(posedge hclk); #2;
      check("lock_release_hgrant", hgrant, 4'b0001);

      // contested handover stalled by hready=0
      for (int i = 0; i < 3; i++) begin
         cycle(4'b0110, 4'b0000, T_IDLE, 1'b0);
         @(posedge hclk); #2;
         check("stall_hgrant", hgrant, 4'b0001);
         check("stall_hmaster", hmaster, 2'd3);
      end
      cycle(4'b0110, 4'b0000, T_IDLE, 1'b1);
      @(posedge hclk); #2;
      check("stall_release_hgrant", hgrant, 4'b0010);
      check("stall_release_hmaster", hmaster, 2'd0);

      // reset pulse in the middle of a locked tenure
      cycle(4'b0100, 4'b0100, T_NONSEQ, 1'b1);
      for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b0100, T_SEQ, 1'b1);
      @(posedge hclk); #2;
      check("prelock_hmastlock", hmastlock, 1'b1);
      do_reset(1);
      cycle(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
      @(posedge hclk); #2;
      check("post_rst_first_win", hgrant, 4'b0001);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
         end else begin
            r = $urandom_range(0, 9);
            tr = (r < 5) ? T_SEQ : (r < 8) ? T_NONSEQ : (r == 8) ? T_BUSY : T_IDLE;
            cycle(4'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
                  tr, $urandom_range(0, 3) != 0);
         end
      end

      @(posedge hclk); #3;
      check("sb_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
